// File: rtl/bneck_pkg.sv
// bneck_pkg: shared constants and read-streamer state encoding for the bottleneck memory.
package bneck_pkg;
    localparam int BNECK_BITSIZE    = 16;
    localparam int BNECK_LANES      = 16;
    localparam int BNECK_HEIGHT     = 12544;
    localparam int BNECK_IDX_W      = 14;
    localparam int BNECK_FIFO_DEPTH = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/bneck_rd_fifo.sv
// bneck_rd_fifo: small register FIFO carrying read data plus last flag, head read straight from storage.
module bneck_rd_fifo
    import bneck_pkg::*;
#(
    parameter int width = BNECK_BITSIZE * BNECK_LANES + 1,
    parameter int depth = BNECK_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [width-1:0]         wdata,
    input  logic                     pop,
    output logic [width-1:0]         head,
    output logic [$clog2(depth):0]   count
);
    localparam int aw = $clog2(depth);
    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wptr, rptr;
    // pointers wrap naturally because depth is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (aw+1)'(push) - (aw+1)'(pop);
        end
    end
    assign head = mem[rptr];
endmodule

// File: rtl/mem_bneck_reader.sv
// mem_bneck_reader: sweeps a wrapping pixel range of the bottleneck memory and streams
// the 16-lane words out on a valid/ready interface with last-beat marking.
module mem_bneck_reader
    import bneck_pkg::*;
#(
    parameter int bitsize    = BNECK_BITSIZE,
    parameter int lanes      = BNECK_LANES,
    parameter int height     = BNECK_HEIGHT,
    parameter int idx_w      = BNECK_IDX_W,
    parameter int fifo_depth = BNECK_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [idx_w-1:0]         base_index,
    input  logic [idx_w:0]           num_pixels,
    output logic [idx_w-1:0]         mem_index,
    output logic                     mem_en,
    output logic                     mem_rd,
    output logic                     mem_wr,
    input  logic [bitsize*lanes-1:0] mem_rdata,
    output logic [bitsize*lanes-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam int dw = bitsize * lanes;
    localparam int cw = $clog2(fifo_depth) + 1;
    rd_state_t        state;
    logic [idx_w:0]   num, issued, issued_inc;
    logic [idx_w-1:0] idx_inc, nxt_index, base_clamp;
    logic             rd_last, rd_d, last_d, pop, can_issue;
    logic [dw:0]      head;
    logic [cw-1:0]    count;
    logic [cw:0]      occ;

    assign idx_inc    = mem_index + 1'b1;
    assign nxt_index  = (idx_inc == idx_w'(height)) ? '0 : idx_inc;
    assign base_clamp = (base_index >= idx_w'(height)) ? base_index - idx_w'(height) : base_index;
    assign issued_inc = issued + 1'b1;
    assign pop        = out_valid & out_ready;
    // entries already buffered plus reads still travelling through the memory
    assign occ        = (cw+1)'(count) + (cw+1)'(rd_d) + (cw+1)'(mem_en) - (cw+1)'(pop);
    assign can_issue  = occ < (cw+1)'(fifo_depth);
    assign out_valid  = count != '0;
    assign out_data   = head[dw-1:0];
    assign out_last   = head[dw] & out_valid;
    assign mem_rd     = mem_en;
    assign mem_wr     = 1'b0;

    bneck_rd_fifo #(.width(dw + 1), .depth(fifo_depth)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_d),
        .wdata ({last_d, mem_rdata}),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            num       <= '0;
            issued    <= '0;
            mem_index <= '0;
            mem_en    <= 1'b0;
            rd_last   <= 1'b0;
            rd_d      <= 1'b0;
            last_d    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_d   <= mem_en;
            last_d <= rd_last;
            case (state)
                IDLE: if (start) begin
                    num <= num_pixels;
                    if (num_pixels == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= (num_pixels == (idx_w+1)'(1)) ? DRAIN : ISSUE;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_index <= base_clamp;
                        issued    <= (idx_w+1)'(1);
                        rd_last   <= num_pixels == (idx_w+1)'(1);
                    end
                end
                ISSUE: begin
                    mem_en <= can_issue;
                    if (can_issue) begin
                        mem_index <= nxt_index;
                        issued    <= issued_inc;
                        rd_last   <= issued_inc == num;
                        if (issued_inc == num) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    mem_en <= 1'b0;
                    if (pop && out_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bneck_reader.sv
// tb_mem_bneck_reader: directed stimulus with a read-index and output-beat scoreboard.
module tb_mem_bneck_reader;
    localparam int H  = 12544;
    localparam int IW = 14;
    localparam int DW = 256;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [IW-1:0]  base_index = '0;
    logic [IW:0]    num_pixels = '0;
    logic [IW-1:0]  mem_index;
    logic           mem_en, mem_rd, mem_wr;
    logic [DW-1:0]  mem_rdata = '0;
    logic [DW-1:0]  out_data;
    logic           out_valid, out_last, busy, done;
    logic           out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int rd_count = 0;
    int beats = 0;
    logic [IW-1:0] idx_q[$];
    logic [DW:0]   beat_q[$];
    logic          hold = 1'b0;
    logic          hold_last;
    logic [DW-1:0] hold_data;

    mem_bneck_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_index(base_index), .num_pixels(num_pixels),
        .mem_index(mem_index), .mem_en(mem_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix(input int idx);
        logic [DW-1:0] d;
        for (int l = 0; l < 16; l++) d[l*16 +: 16] = 16'((idx * 37 + l * 1021 + 5) & 16'hffff);
        return d;
    endfunction

    always @(posedge clk) if (mem_en && mem_rd) mem_rdata <= pix(int'(mem_index));

    task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst) hold = 1'b0;
        else begin
            if (mem_en) begin
                rd_count++;
                if (idx_q.size() == 0) chk("unexpected_read", (DW+1)'(mem_index), '1);
                else chk("mem_index", (DW+1)'(mem_index), (DW+1)'(idx_q.pop_front()));
            end
            if (hold) begin
                chk("hold_valid", (DW+1)'(out_valid), 1);
                chk("hold_data", (DW+1)'(out_data), (DW+1)'(hold_data));
                chk("hold_last", (DW+1)'(out_last), (DW+1)'(hold_last));
            end
            if (out_valid && out_ready) begin
                beats++;
                if (beat_q.size() == 0) chk("unexpected_beat", (DW+1)'(out_data), '1);
                else chk("beat", {out_last, out_data}, beat_q.pop_front());
            end
            hold      = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end
    end

    // drives a start pulse and returns at the negedge of cycle 1
    task automatic cmd(input int base, input int n);
        int b;
        @(negedge clk);
        start      = 1'b1;
        base_index = IW'(base);
        num_pixels = (IW+1)'(n);
        b = base >= H ? base - H : base;
        for (int k = 0; k < n; k++) begin
            idx_q.push_back(IW'((b + k) % H));
            beat_q.push_back({k == n - 1, pix((b + k) % H)});
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(tag, (DW+1)'(done), 1);
        @(negedge clk);
        chk({tag, "_queue"}, (DW+1)'(idx_q.size() + beat_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, b0, t;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", (DW+1)'({mem_en, mem_rd, mem_wr}), 0);
        chk("rst_mem_index", (DW+1)'(mem_index), 0);
        chk("rst_out", {out_last, out_data}, 0);
        chk("rst_flags", (DW+1)'({out_valid, busy, done}), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_flags", (DW+1)'({out_valid, busy, done, mem_en}), 0);

        // burst of 4 with exact cycle timing
        out_ready = 1'b1;
        cmd(10, 4);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("b4_en_c%0d", c), (DW+1)'(mem_en), (DW+1)'(c <= 4));
            chk($sformatf("b4_valid_c%0d", c), (DW+1)'(out_valid), (DW+1)'(c >= 3 && c <= 6));
            chk($sformatf("b4_last_c%0d", c), (DW+1)'(out_last), (DW+1)'(c == 6));
            chk($sformatf("b4_done_c%0d", c), (DW+1)'(done), (DW+1)'(c == 7));
            chk($sformatf("b4_busy_c%0d", c), (DW+1)'(busy), (DW+1)'(c <= 6));
            chk($sformatf("b4_wr_c%0d", c), (DW+1)'(mem_wr), 0);
            @(negedge clk);
        end
        chk("b4_queue", (DW+1)'(idx_q.size() + beat_q.size()), 0);

        // backpressure: only fifo_depth reads may be outstanding
        out_ready = 1'b0;
        r0 = rd_count;
        b0 = beats;
        cmd(0, 8);
        repeat (9) @(negedge clk);
        chk("bp_reads", (DW+1)'(rd_count - r0), 4);
        chk("bp_en_off", (DW+1)'(mem_en), 0);
        chk("bp_valid", (DW+1)'(out_valid), 1);
        out_ready = 1'b1;
        wait_done("bp_done");
        chk("bp_beats", (DW+1)'(beats - b0), 8);

        // wrap across the end of the memory, then an out-of-range base
        cmd(12542, 4);
        wait_done("wrap_done");
        cmd(12600, 2);
        wait_done("clamp_done");

        // zero-length command
        r0 = rd_count;
        cmd(0, 0);
        chk("zero_done", (DW+1)'(done), 1);
        chk("zero_busy", (DW+1)'(busy), 0);
        @(negedge clk);
        chk("zero_done_off", (DW+1)'(done), 0);
        chk("zero_reads", (DW+1)'(rd_count - r0), 0);

        // start while busy is ignored
        b0 = beats;
        cmd(200, 16);
        repeat (2) @(negedge clk);
        start = 1'b1;
        base_index = IW'(5000);
        num_pixels = (IW+1)'(3);
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_done");
        chk("ign_beats", (DW+1)'(beats - b0), 16);

        // reset in the middle of a burst
        b0 = beats;
        cmd(300, 16);
        t = 0;
        while (beats < b0 + 5 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk("mid_beats", (DW+1)'(beats - b0), 5);
        rst = 1'b0;
        #1;
        chk("mid_rst_mem", (DW+1)'({mem_en, mem_rd, mem_index}), 0);
        chk("mid_rst_out", {out_valid, out_last, out_data}, 0);
        chk("mid_rst_flags", (DW+1)'({busy, done}), 0);
        idx_q.delete();
        beat_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        r0 = rd_count;
        b0 = beats;
        cmd(100, 2);
        wait_done("post_done");
        chk("post_reads", (DW+1)'(rd_count - r0), 2);
        chk("post_beats", (DW+1)'(beats - b0), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
